// File: rtl/alt_vipcts131_common_stream_output_sync_ctrl_pkg.sv
// Shared definitions for the stream-output sync controller: state encoding and
// timeout counter sizing.
package alt_vipcts131_common_stream_output_sync_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } sync_state_e;

    // Width needed to hold 0..cycles-1; never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/alt_vipcts131_common_timeout_counter.sv
// Free-running timeout counter: synchronous clear, count enable, and an expired
// flag decoded from the registered count on its final value.
module alt_vipcts131_common_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_W          = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alt_vipcts131_common_stream_output_sync_ctrl.sv
// Starts and stops a group of stream-output stages together on image-packet
// boundaries, counting frames and flagging stages that never reach a boundary.
module alt_vipcts131_common_stream_output_sync_ctrl
    import alt_vipcts131_common_stream_output_sync_ctrl_pkg::*;
#(
    parameter int unsigned NUM_OUTPUTS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned FRAME_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [NUM_OUTPUTS-1:0] out_mask,
    input  logic [FRAME_W-1:0]     frame_limit,
    input  logic                   frame_tick,
    input  logic [NUM_OUTPUTS-1:0] synced,
    output logic [NUM_OUTPUTS-1:0] enable,
    output logic                   busy,
    output logic                   running,
    output logic                   error,
    output logic [FRAME_W-1:0]     frames_done
);

    localparam int unsigned TMR_W = timer_width(TIMEOUT_CYCLES);

    sync_state_e            r_state;
    logic [NUM_OUTPUTS-1:0] r_mask;
    logic [NUM_OUTPUTS-1:0] r_enable;
    logic [FRAME_W-1:0]     r_limit;
    logic [FRAME_W-1:0]     r_frames;
    logic                   r_error;

    logic                   w_expired;
    logic                   w_tmr_clear;
    logic                   w_tmr_count;
    logic                   w_leave_start;
    logic                   w_leave_stop;
    logic [NUM_OUTPUTS-1:0] w_masked_sync;
    logic                   w_all_halted;
    logic                   w_all_running;
    logic [FRAME_W-1:0]     w_frames_inc;
    logic                   w_limit_hit;

    assign w_masked_sync = synced & r_mask;
    assign w_all_halted  = (w_masked_sync == r_mask);
    assign w_all_running = (w_masked_sync == '0);
    assign w_frames_inc  = (r_frames == '1) ? r_frames : r_frames + 1'b1;
    assign w_limit_hit   = (r_limit != '0) && (w_frames_inc == r_limit);

    // Timer only accumulates while waiting in START/STOP; any exit restarts it.
    always_comb begin
        w_leave_start = w_all_running || stop || w_expired;
        w_leave_stop  = w_all_halted || w_expired;
        w_tmr_count   = (r_state == ST_START) || (r_state == ST_STOP);
        w_tmr_clear   = !(((r_state == ST_START) && !w_leave_start) ||
                          ((r_state == ST_STOP)  && !w_leave_stop));
    end

    alt_vipcts131_common_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (TMR_W)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_tmr_clear),
        .i_count  (w_tmr_count),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mask   <= '0;
            r_enable <= '0;
            r_limit  <= '0;
            r_frames <= '0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop && (out_mask != '0)) begin
                        r_mask   <= out_mask;
                        r_limit  <= frame_limit;
                        r_enable <= out_mask;
                        r_error  <= 1'b0;
                        r_frames <= '0;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_all_running) begin
                        r_state <= ST_RUN;
                    end else if (stop) begin
                        r_enable <= '0;
                        r_state  <= ST_STOP;
                    end else if (w_expired) begin
                        r_error  <= 1'b1;
                        r_enable <= '0;
                        r_state  <= ST_STOP;
                    end
                end
                ST_RUN: begin
                    if (frame_tick) begin
                        r_frames <= w_frames_inc;
                    end
                    if ((frame_tick && w_limit_hit) || stop) begin
                        r_enable <= '0;
                        r_state  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_all_halted) begin
                        r_state <= ST_IDLE;
                    end else if (w_expired) begin
                        r_error <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign enable      = r_enable;
    assign busy        = (r_state != ST_IDLE);
    assign running     = (r_state == ST_RUN);
    assign error       = r_error;
    assign frames_done = r_frames;

endmodule

// File: tb/tb_alt_vipcts131_common_stream_output_sync_ctrl.sv
// Scoreboard bench: stimulus queues the expected output snapshot and the cycle it
// should appear; a negedge monitor compares every output change and every probe.
module tb_alt_vipcts131_common_stream_output_sync_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, frame_tick;
    logic [1:0]  out_mask, synced, enable;
    logic [15:0] frame_limit, frames_done;
    logic        busy, running, error;

    alt_vipcts131_common_stream_output_sync_ctrl #(
        .NUM_OUTPUTS   (2),
        .TIMEOUT_CYCLES(16),
        .FRAME_W       (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .out_mask   (out_mask),
        .frame_limit(frame_limit),
        .frame_tick (frame_tick),
        .synced     (synced),
        .enable     (enable),
        .busy       (busy),
        .running    (running),
        .error      (error),
        .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          probe;
        int          cyc;
        logic [20:0] snap;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [20:0] mk(input logic [1:0] en, input logic b, input logic r,
                                       input logic e, input logic [15:0] fd);
        return {en, b, r, e, fd};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chg(input int c, input logic [20:0] s, input string nm);
        q.push_back('{probe: 1'b0, cyc: c, snap: s, name: nm});
    endtask

    task automatic probe(input int c, input logic [20:0] s, input string nm);
        q.push_back('{probe: 1'b1, cyc: c, snap: s, name: nm});
    endtask

    task automatic rand_steps(input int n);
        repeat (n) begin
            synced[1] = 1'($urandom_range(0, 1));
            step(1);
        end
    endtask

    // Monitor: snapshot is {enable, busy, running, error, frames_done}.
    logic [20:0] m_cur, m_prev;
    bit          m_first = 1'b1;
    exp_t        m_e;
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                m_cur = {enable, busy, running, error, frames_done};
                while (q.size() > 0 && q[0].probe && q[0].cyc <= cyc) begin
                    m_e = q.pop_front();
                    checks++;
                    if (m_e.cyc != cyc || m_cur !== m_e.snap) begin
                        failures++;
                        $display("FAIL %s: actual=%h @cyc %0d required=%h @cyc %0d",
                                 m_e.name, m_cur, cyc, m_e.snap, m_e.cyc);
                    end
                end
                if (!m_first && m_cur !== m_prev) begin
                    checks++;
                    if (q.size() == 0 || q[0].probe) begin
                        failures++;
                        $display("FAIL unexpected_change: actual=%h @cyc %0d required=%h",
                                 m_cur, cyc, m_prev);
                    end else begin
                        m_e = q.pop_front();
                        if (m_e.cyc != cyc || m_cur !== m_e.snap) begin
                            failures++;
                            $display("FAIL %s: actual=%h @cyc %0d required=%h @cyc %0d",
                                     m_e.name, m_cur, cyc, m_e.snap, m_e.cyc);
                        end
                    end
                end
                m_prev  = m_cur;
                m_first = 1'b0;
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; frame_tick = 1'b0;
        out_mask = 2'b00; frame_limit = 16'd0; synced = 2'b11;
        step(2);
        probe(cyc, mk(2'b00, 0, 0, 0, 16'd0), "reset_state");
        rst_n = 1'b1;
        step(1);

        // Bounded run: limit 3, staggered synced release.
        start = 1'b1; out_mask = 2'b11; frame_limit = 16'd3;
        chg(cyc + 1, mk(2'b11, 1, 0, 0, 16'd0), "t2_start");
        step(1);
        start = 1'b0;
        step(5);
        synced[0] = 1'b0;
        step(4);
        synced[1] = 1'b0;
        chg(cyc + 1, mk(2'b11, 1, 1, 0, 16'd0), "t2_run_at_clk10");
        step(1);
        for (int k = 1; k <= 3; k++) begin
            step(2);
            frame_tick = 1'b1;
            if (k < 3) chg(cyc + 1, mk(2'b11, 1, 1, 0, 16'(k)), "t2_tick");
            else       chg(cyc + 1, mk(2'b00, 1, 0, 0, 16'd3), "t2_limit_stop");
            step(1);
            frame_tick = 1'b0;
        end
        step(2);
        synced = 2'b11;
        chg(cyc + 1, mk(2'b00, 0, 0, 0, 16'd3), "t2_idle");
        step(2);

        // Continuous run: 100 ticks then stop.
        start = 1'b1; frame_limit = 16'd0;
        chg(cyc + 1, mk(2'b11, 1, 0, 0, 16'd0), "t3a_start");
        step(1);
        start = 1'b0; synced = 2'b00;
        chg(cyc + 1, mk(2'b11, 1, 1, 0, 16'd0), "t3a_run");
        step(1);
        for (int k = 1; k <= 100; k++) begin
            frame_tick = 1'b1;
            chg(cyc + 1, mk(2'b11, 1, 1, 0, 16'(k)), "t3a_tick");
            step(1);
            frame_tick = 1'b0;
            step(1);
        end
        stop = 1'b1;
        chg(cyc + 1, mk(2'b00, 1, 0, 0, 16'd100), "t3a_stop");
        step(1);
        stop = 1'b0;
        step(2);
        synced = 2'b11;
        chg(cyc + 1, mk(2'b00, 0, 0, 0, 16'd100), "t3a_idle");
        step(2);

        // Tick and stop together, then STOP times out with stages never halting.
        start = 1'b1;
        chg(cyc + 1, mk(2'b11, 1, 0, 0, 16'd0), "t3b_start");
        step(1);
        start = 1'b0; synced = 2'b00;
        chg(cyc + 1, mk(2'b11, 1, 1, 0, 16'd0), "t3b_run");
        step(1);
        for (int k = 1; k <= 2; k++) begin
            frame_tick = 1'b1;
            chg(cyc + 1, mk(2'b11, 1, 1, 0, 16'(k)), "t3b_tick");
            step(1);
            frame_tick = 1'b0;
            step(1);
        end
        frame_tick = 1'b1; stop = 1'b1;
        chg(cyc + 1, mk(2'b00, 1, 0, 0, 16'd3), "t3b_tick_and_stop");
        chg(cyc + 17, mk(2'b00, 0, 0, 1, 16'd3), "t3b_stop_timeout");
        step(1);
        frame_tick = 1'b0; stop = 1'b0;
        step(18);

        // START timeout with synced[1] stuck high; next start clears error.
        synced = 2'b10;
        step(1);
        start = 1'b1;
        chg(cyc + 1, mk(2'b11, 1, 0, 0, 16'd0), "t4_start_clears_err");
        chg(cyc + 17, mk(2'b00, 1, 0, 1, 16'd0), "t4_start_timeout");
        step(1);
        start = 1'b0;
        step(17);
        synced = 2'b11;
        chg(cyc + 1, mk(2'b00, 0, 0, 1, 16'd0), "t4_idle_err");
        step(2);
        start = 1'b1;
        chg(cyc + 1, mk(2'b11, 1, 0, 0, 16'd0), "t4_restart");
        step(1);
        start = 1'b0; stop = 1'b1;
        chg(cyc + 1, mk(2'b00, 1, 0, 0, 16'd0), "t4_stop_in_start");
        chg(cyc + 2, mk(2'b00, 0, 0, 0, 16'd0), "t4_idle");
        step(1);
        stop = 1'b0;
        step(3);

        // Ignored starts.
        start = 1'b1; out_mask = 2'b00;
        probe(cyc + 1, mk(2'b00, 0, 0, 0, 16'd0), "t5_zero_mask");
        step(1);
        start = 1'b1; stop = 1'b1; out_mask = 2'b11;
        probe(cyc + 1, mk(2'b00, 0, 0, 0, 16'd0), "t5_start_stop");
        step(1);
        start = 1'b0; stop = 1'b0;
        step(1);
        start = 1'b1; frame_limit = 16'd0;
        chg(cyc + 1, mk(2'b11, 1, 0, 0, 16'd0), "t5_start");
        step(1);
        start = 1'b0; synced = 2'b00;
        chg(cyc + 1, mk(2'b11, 1, 1, 0, 16'd0), "t5_run");
        step(1);
        start = 1'b1; out_mask = 2'b01; frame_limit = 16'd1;
        probe(cyc + 1, mk(2'b11, 1, 1, 0, 16'd0), "t5_start_in_run");
        step(1);
        start = 1'b0; frame_tick = 1'b1;
        chg(cyc + 1, mk(2'b11, 1, 1, 0, 16'd1), "t5_limit_not_relatched");
        step(1);
        frame_tick = 1'b0; stop = 1'b1;
        chg(cyc + 1, mk(2'b00, 1, 0, 0, 16'd1), "t5_stop");
        step(1);
        stop = 1'b0; synced = 2'b11;
        chg(cyc + 1, mk(2'b00, 0, 0, 0, 16'd1), "t5_idle");
        step(2);

        // Partial mask: synced[1] is noise throughout.
        start = 1'b1; out_mask = 2'b01; frame_limit = 16'd2;
        chg(cyc + 1, mk(2'b01, 1, 0, 0, 16'd0), "t6_start");
        step(1);
        start = 1'b0;
        rand_steps(4);
        synced[0] = 1'b0;
        chg(cyc + 1, mk(2'b01, 1, 1, 0, 16'd0), "t6_run");
        rand_steps(3);
        frame_tick = 1'b1;
        chg(cyc + 1, mk(2'b01, 1, 1, 0, 16'd1), "t6_tick");
        rand_steps(1);
        frame_tick = 1'b0;
        rand_steps(2);
        frame_tick = 1'b1;
        chg(cyc + 1, mk(2'b00, 1, 0, 0, 16'd2), "t6_limit_stop");
        rand_steps(1);
        frame_tick = 1'b0;
        rand_steps(4);
        synced[0] = 1'b1;
        chg(cyc + 1, mk(2'b00, 0, 0, 0, 16'd2), "t6_idle");
        rand_steps(3);
        synced = 2'b11;
        step(1);

        // Asynchronous reset in the middle of a run.
        start = 1'b1; out_mask = 2'b11; frame_limit = 16'd0;
        chg(cyc + 1, mk(2'b11, 1, 0, 0, 16'd0), "t1_start");
        step(1);
        start = 1'b0; synced = 2'b00;
        chg(cyc + 1, mk(2'b11, 1, 1, 0, 16'd0), "t1_run");
        step(1);
        for (int k = 1; k <= 2; k++) begin
            frame_tick = 1'b1;
            chg(cyc + 1, mk(2'b11, 1, 1, 0, 16'(k)), "t1_tick");
            step(1);
            frame_tick = 1'b0;
            step(1);
        end
        rst_n = 1'b0;
        chg(cyc, mk(2'b00, 0, 0, 0, 16'd0), "t1_async_reset");
        probe(cyc + 1, mk(2'b00, 0, 0, 0, 16'd0), "t1_reset_held");
        step(2);
        rst_n = 1'b1;
        step(2);

        for (int i = 0; i < 20 && q.size() != 0; i++) step(1);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_expectations: actual=%0d outstanding required=0 (head %s)",
                     q.size(), q[0].name);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
